// File: rtl/itch_cancel_stream_decoder.sv
// ITCH Order Cancel ('X') / Order Delete ('D') streaming payload decoder.
// Assembles order_ref/shares across beats and queues one record per message.
module itch_cancel_stream_decoder #(
    parameter int BEAT_BYTES = 8,
    parameter int OUT_DEPTH  = 4,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*BEAT_BYTES-1:0] in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_is_del,
    output logic [63:0]             out_order_ref,
    output logic [31:0]             out_shares,
    output logic                    err_pulse,
    output logic [ERR_CNT_W-1:0]    err_count
);
    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int DW = 8 * BEAT_BYTES;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_t;

    typedef struct packed {
        logic        is_del;
        logic [63:0] order_ref;
        logic [31:0] shares;
    } rec_t;

    state_t               state_q, state_d;
    logic [5:0]           byte_idx_q, byte_idx_d;
    logic                 is_del_q, is_del_d;
    logic [63:0]          ref_q, ref_d;
    logic [31:0]          shares_q, shares_d;
    rec_t                 fifo_q [OUT_DEPTH];
    rec_t                 fifo_d [OUT_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 err_pulse_q, err_pulse_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    logic [DW-1:0] data;
    logic [7:0]    type_byte;
    logic          accept, pop, push, err_d;
    logic          cur_del, type_ok, complete;
    logic [5:0]    base, req_len;
    rec_t          head;

    // Idle beats are masked so nothing downstream sees in_data
    assign data      = in_valid ? in_data : '0;
    assign type_byte = data[DW-1 -: 8];
    assign in_ready  = rst_n && (count_q < CW'(OUT_DEPTH));
    assign accept    = in_valid && in_ready;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign head      = fifo_q[rd_ptr_q];

    assign out_is_del    = out_valid && head.is_del;
    assign out_order_ref = out_valid ? head.order_ref : '0;
    assign out_shares    = out_valid ? head.shares : '0;
    assign err_pulse     = err_pulse_q;
    assign err_count     = err_count_q;

    // Message FSM: type check, capture by absolute byte index, completion
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        is_del_d   = is_del_q;
        ref_d      = ref_q;
        shares_d   = shares_q;
        err_d      = 1'b0;
        push       = 1'b0;
        base       = (state_q == S_IDLE) ? 6'd0 : byte_idx_q;
        cur_del    = (state_q == S_IDLE) ? (type_byte == 8'h44) : is_del_q;
        type_ok    = (state_q != S_IDLE) ||
                     (type_byte == 8'h58) || (type_byte == 8'h44);
        req_len    = cur_del ? 6'd9 : 6'd13;
        complete   = (base + 6'(BEAT_BYTES)) >= req_len;
        if (accept) begin
            unique case (state_q)
                S_IDLE, S_COLLECT: begin
                    if (!type_ok) begin
                        err_d      = 1'b1;
                        byte_idx_d = '0;
                        state_d    = in_last ? S_IDLE : S_DRAIN;
                    end else begin
                        if (state_q == S_IDLE) begin
                            ref_d    = '0;
                            shares_d = '0;
                            is_del_d = cur_del;
                        end
                        for (int k = 0; k < BEAT_BYTES; k++) begin
                            for (int j = 0; j < 8; j++) begin
                                if (base + 6'(k) == 6'(j + 1))
                                    ref_d[63-8*j -: 8] = data[DW-1-8*k -: 8];
                            end
                            for (int j = 0; j < 4; j++) begin
                                if (!cur_del && (base + 6'(k) == 6'(j + 9)))
                                    shares_d[31-8*j -: 8] = data[DW-1-8*k -: 8];
                            end
                        end
                        if (complete) begin
                            push       = 1'b1;
                            err_d      = !in_last;
                            byte_idx_d = '0;
                            state_d    = in_last ? S_IDLE : S_DRAIN;
                        end else if (in_last) begin
                            err_d      = 1'b1;
                            byte_idx_d = '0;
                            state_d    = S_IDLE;
                        end else begin
                            byte_idx_d = base + 6'(BEAT_BYTES);
                            state_d    = S_COLLECT;
                        end
                    end
                end
                S_DRAIN: begin
                    if (in_last) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output FIFO bookkeeping and saturating error counter
    always_comb begin
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        err_pulse_d = err_d;
        err_count_d = err_count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = '{is_del: cur_del, order_ref: ref_d,
                                 shares: shares_d};
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + CW'(push) - CW'(pop);
        if (err_d && !(&err_count_q)) err_count_d = err_count_q + 1'b1;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            byte_idx_q  <= '0;
            is_del_q    <= 1'b0;
            ref_q       <= '0;
            shares_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            is_del_q    <= is_del_d;
            ref_q       <= ref_d;
            shares_q    <= shares_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            fifo_q      <= fifo_d;
        end
    end
endmodule

// File: tb/tb_itch_cancel_stream_decoder.sv
// Bench for itch_cancel_stream_decoder: an 8-byte-beat instance and a
// 16-byte-beat instance with a 2-bit error counter, checked against a message model.
module tb_itch_cancel_stream_decoder;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready;
    logic a_out_is_del, a_err_pulse;
    logic [63:0] a_in_data, a_out_ref;
    logic [31:0] a_out_sh;
    logic [15:0] a_err_count;

    logic b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready;
    logic b_out_is_del, b_err_pulse;
    logic [127:0] b_in_data;
    logic [63:0]  b_out_ref;
    logic [31:0]  b_out_sh;
    logic [1:0]   b_err_count;

    itch_cancel_stream_decoder #(.BEAT_BYTES(8), .OUT_DEPTH(4), .ERR_CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_last(a_in_last), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_is_del(a_out_is_del), .out_order_ref(a_out_ref),
        .out_shares(a_out_sh), .err_pulse(a_err_pulse), .err_count(a_err_count));

    itch_cancel_stream_decoder #(.BEAT_BYTES(16), .OUT_DEPTH(4), .ERR_CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_last(b_in_last), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_is_del(b_out_is_del), .out_order_ref(b_out_ref),
        .out_shares(b_out_sh), .err_pulse(b_err_pulse), .err_count(b_err_count));

    typedef logic [96:0] rec_t;
    rec_t exp_a[$], exp_b[$], rx_a[$], rx_b[$];
    int   rd_a = 0, rd_b = 0;
    int   exp_err_a = 0, exp_err_b = 0, exp_pul_a = 0, exp_pul_b = 0;
    int   pulses_a = 0, pulses_b = 0;
    int   checks = 0, errors = 0;
    bit   auto_rdy = 1'b0;

    // Capture every popped record and every error pulse
    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_out_ready)
            rx_a.push_back({a_out_is_del, a_out_ref, a_out_sh});
        if (rst_n && b_out_valid && b_out_ready)
            rx_b.push_back({b_out_is_del, b_out_ref, b_out_sh});
        if (a_err_pulse) pulses_a++;
        if (b_err_pulse) pulses_b++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Message-level reference: outcome depends only on type, beats and beat width
    function automatic void ref_model(input logic [7:0] typ, input int nb, input int bb,
                                      output bit rec, output bit err);
        int req, need;
        if (typ != 8'h58 && typ != 8'h44) begin
            rec = 1'b0;
            err = 1'b1;
            return;
        end
        req  = (typ == 8'h44) ? 9 : 13;
        need = (req + bb - 1) / bb;
        rec  = (nb >= need);
        err  = (nb != need);
    endfunction

    task automatic beat(input bit sel, input logic [127:0] d, input bit last);
        int n;
        n = 0;
        if (!sel) begin
            a_in_valid = 1'b1; a_in_data = d[63:0]; a_in_last = last;
        end else begin
            b_in_valid = 1'b1; b_in_data = d; b_in_last = last;
        end
        forever begin
            @(negedge clk);
            if ((!sel && a_in_ready) || (sel && b_in_ready)) break;
            n++;
            if (n > 100) break;
            @(posedge clk);
            #1;
            if (auto_rdy) begin
                if (!sel) a_out_ready = 1'b1;
                else b_out_ready = 1'b1;
            end
        end
        if (n > 100) begin
            checks++;
            errors++;
            $error("FAIL beat_timeout: observed in_ready=0 expected 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        a_in_valid = 1'b0; a_in_last = 1'b0; a_in_data = {$urandom, $urandom};
        b_in_valid = 1'b0; b_in_last = 1'b0;
        b_in_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic send_msg(input bit sel, input logic [7:0] typ, input int nb,
                            input logic [63:0] r, input logic [31:0] s);
        logic [7:0]   m [48];
        logic [127:0] d;
        int bb;
        bit rec, err;
        bb = sel ? 16 : 8;
        for (int i = 0; i < 48; i++) m[i] = 8'($urandom);
        m[0] = typ;
        for (int j = 0; j < 8; j++) m[1+j] = r[63-8*j -: 8];
        for (int j = 0; j < 4; j++) m[9+j] = s[31-8*j -: 8];
        for (int b = 0; b < nb; b++) begin
            d = '0;
            for (int l = 0; l < bb; l++) d[8*bb-1-8*l -: 8] = m[b*bb+l];
            beat(sel, d, b == nb - 1);
        end
        ref_model(typ, nb, bb, rec, err);
        if (rec) begin
            if (!sel) exp_a.push_back({typ == 8'h44, r, (typ == 8'h44) ? 32'h0 : s});
            else exp_b.push_back({typ == 8'h44, r, (typ == 8'h44) ? 32'h0 : s});
        end
        if (err) begin
            if (!sel) begin
                exp_pul_a++;
                if (exp_err_a < 65535) exp_err_a++;
            end else begin
                exp_pul_b++;
                if (exp_err_b < 3) exp_err_b++;
            end
        end
    endtask

    task automatic check_fifo(input bit sel);
        int got;
        rec_t e;
        if (!sel) a_out_ready = 1'b1;
        else b_out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            got = sel ? rx_b.size() - rd_b : rx_a.size() - rd_a;
            if (got == (sel ? exp_b.size() : exp_a.size()) &&
                !(sel ? b_out_valid : a_out_valid)) break;
        end
        got = sel ? rx_b.size() - rd_b : rx_a.size() - rd_a;
        chk(sel ? "b_rec_count" : "a_rec_count", got, sel ? exp_b.size() : exp_a.size());
        if (!sel) begin
            while (exp_a.size() > 0 && rd_a < rx_a.size()) begin
                e = exp_a.pop_front();
                chk("a_record", rx_a[rd_a], e);
                rd_a++;
            end
            exp_a.delete();
            rd_a = rx_a.size();
            chk("a_err_count", a_err_count, exp_err_a);
            chk("a_err_pulses", pulses_a, exp_pul_a);
        end else begin
            while (exp_b.size() > 0 && rd_b < rx_b.size()) begin
                e = exp_b.pop_front();
                chk("b_record", rx_b[rd_b], e);
                rd_b++;
            end
            exp_b.delete();
            rd_b = rx_b.size();
            chk("b_err_count", b_err_count, exp_err_b);
            chk("b_err_pulses", pulses_b, exp_pul_b);
        end
    endtask

    function automatic logic [7:0] bad_type();
        logic [7:0] t;
        t = 8'($urandom);
        while (t == 8'h58 || t == 8'h44) t = 8'($urandom);
        return t;
    endfunction

    initial begin
        logic [7:0]   typ;
        logic [127:0] d;
        int           sel_t;
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_last = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_last = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_fields", {a_out_is_del, a_out_ref, a_out_sh}, 0);
        chk("rst_err", {a_err_pulse, a_err_count}, 0);
        chk("rst_b_out_valid", b_out_valid, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_in_ready", a_in_ready, 1);

        // Cancel over two beats, record visible right after the last beat
        send_msg(0, 8'h58, 2, 64'h0011223344556677, 32'h000003E8);
        chk("x_out_valid", a_out_valid, 1);
        chk("x_is_del", a_out_is_del, 0);
        chk("x_ref", a_out_ref, 64'h0011223344556677);
        chk("x_shares", a_out_sh, 32'h000003E8);
        chk("x_no_err", a_err_pulse, 0);
        check_fifo(0);

        // Delete on both beat widths
        send_msg(0, 8'h44, 2, 64'hDEADBEEFCAFEF00D, 32'hFFFFFFFF);
        check_fifo(0);
        send_msg(1, 8'h44, 1, 64'hDEADBEEFCAFEF00D, 32'h12345678);
        send_msg(1, 8'h58, 1, 64'h0102030405060708, 32'h0A0B0C0D);
        check_fifo(1);

        // Unknown type, then a good cancel
        send_msg(0, 8'h41, 3, 64'h1, 32'h2);
        send_msg(0, 8'h58, 2, 64'hA5A5A5A55A5A5A5A, 32'h00000007);
        check_fifo(0);

        // Truncated cancel, trailing-byte cancel, truncated delete
        send_msg(0, 8'h58, 1, 64'h3, 32'h4);
        chk("trunc_err_pulse", a_err_pulse, 1);
        send_msg(0, 8'h58, 3, 64'hFEDCBA9876543210, 32'h11223344);
        send_msg(0, 8'h44, 1, 64'h5, 32'h6);
        check_fifo(0);

        // Backpressure: fill the FIFO and verify the head holds
        a_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_msg(0, 8'h44, 2, {$urandom, $urandom}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_in_ready", a_in_ready, 0);
            chk("full_head", {a_out_is_del, a_out_ref, a_out_sh}, exp_a[0]);
        end
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
        for (int i = 0; i < 2; i++) send_msg(0, 8'h44, 2, {$urandom, $urandom}, 32'h0);
        check_fifo(0);

        // Reset mid-message with records queued
        a_out_ready = 1'b0;
        send_msg(0, 8'h44, 2, 64'h77, 32'h0);
        send_msg(0, 8'h44, 2, 64'h88, 32'h0);
        d = '0;
        d[63:56] = 8'h58;
        beat(0, d, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", a_out_valid, 0);
        chk("midrst_err_count", a_err_count, 0);
        chk("midrst_in_ready", a_in_ready, 0);
        exp_a.delete();
        exp_b.delete();
        exp_err_a = 0;
        exp_err_b = 0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_msg(0, 8'h58, 2, 64'h0BADF00D12345678, 32'h0000BEEF);
        check_fifo(0);

        // Saturation of the 2-bit counter
        for (int i = 0; i < 5; i++) send_msg(1, bad_type(), 1, 64'h0, 32'h0);
        check_fifo(1);

        // Randomized traffic with random consumer stalls
        auto_rdy = 1'b1;
        for (int i = 0; i < 80; i++) begin
            sel_t = $urandom_range(0, 3);
            typ = (sel_t == 0) ? bad_type() : (sel_t == 1) ? 8'h44 : 8'h58;
            a_out_ready = 1'($urandom_range(0, 1));
            send_msg(0, typ, $urandom_range(1, 3), {$urandom, $urandom}, $urandom);
        end
        check_fifo(0);
        for (int i = 0; i < 30; i++) begin
            sel_t = $urandom_range(0, 3);
            typ = (sel_t == 0) ? bad_type() : (sel_t == 1) ? 8'h44 : 8'h58;
            b_out_ready = 1'($urandom_range(0, 1));
            send_msg(1, typ, $urandom_range(1, 3), {$urandom, $urandom}, $urandom);
        end
        check_fifo(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
